// File: rtl/kg_pkg.sv
// Shared constants for the Kugelblitz offload register file: word map, ID value
// and AXI response codes.
package kg_pkg;

    localparam logic [2:0] KG_REG_ADDR       = 3'd0;
    localparam logic [2:0] KG_REG_ADDR_VALID = 3'd1;
    localparam logic [2:0] KG_REG_DATA       = 3'd2;
    localparam logic [2:0] KG_REG_DATA_VALID = 3'd3;
    localparam logic [2:0] KG_REG_ID         = 3'd4;

    localparam int         KG_NUM_RW_REGS    = 4;
    localparam logic [31:0] KG_ID_VALUE      = 32'h4B47_0001;

    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;

endpackage

// File: rtl/kg_strb_reg.sv
// One control word with per-byte write enables and asynchronous active-low clear.
module kg_strb_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [STRB_WIDTH-1:0] strb,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] val_q;
    logic [DATA_WIDTH-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (strb[b]) begin
                    val_d[b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/axil_kg_reg_file.sv
// AXI4-Lite slave holding the per-port Kugelblitz byte-substitution control words.
// Map repeats every 32 bytes; AW and W are only taken together.
module axil_kg_reg_file
    import kg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,

    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,

    output logic [DATA_WIDTH-1:0] kg_address,
    output logic [DATA_WIDTH-1:0] kg_address_valid,
    output logic [DATA_WIDTH-1:0] kg_data,
    output logic [DATA_WIDTH-1:0] kg_data_valid
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("axil_kg_reg_file: only DATA_WIDTH=32 is supported");
    end
    if (STRB_WIDTH * 8 != DATA_WIDTH) begin : g_bad_strb
        $error("axil_kg_reg_file: STRB_WIDTH*8 must equal DATA_WIDTH");
    end

    logic                  wr_acc_q, wr_acc_d;
    logic                  bvalid_q, bvalid_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  wr_en;
    logic                  rd_en;
    logic [2:0]            wr_idx;
    logic [2:0]            rd_idx;
    logic [DATA_WIDTH-1:0] rd_mux;

    logic [KG_NUM_RW_REGS-1:0][DATA_WIDTH-1:0] reg_q;

    assign wr_idx = s_axil_awaddr[4:2];
    assign rd_idx = s_axil_araddr[4:2];

    // The ready flop doubles as a one-cycle lockout so a held AW/W pair is not taken twice.
    assign wr_en = s_axil_awvalid && s_axil_wvalid && !bvalid_q && !wr_acc_q;
    assign rd_en = s_axil_arvalid && !rvalid_q && !arready_q;

    for (genvar i = 0; i < KG_NUM_RW_REGS; i++) begin : g_reg
        kg_strb_reg #(
            .DATA_WIDTH (DATA_WIDTH),
            .STRB_WIDTH (STRB_WIDTH)
        ) u_reg (
            .clk   (clk),
            .rst   (rst),
            .we    (wr_en && (wr_idx == 3'(i))),
            .strb  (s_axil_wstrb),
            .wdata (s_axil_wdata),
            .q     (reg_q[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            KG_REG_ADDR:       rd_mux = reg_q[0];
            KG_REG_ADDR_VALID: rd_mux = reg_q[1];
            KG_REG_DATA:       rd_mux = reg_q[2];
            KG_REG_DATA_VALID: rd_mux = reg_q[3];
            KG_REG_ID:         rd_mux = DATA_WIDTH'(KG_ID_VALUE);
            default:           rd_mux = '0;
        endcase
    end

    always_comb begin
        wr_acc_d  = wr_en;
        bvalid_d  = bvalid_q;
        arready_d = rd_en;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;

        if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end
        if (wr_en) begin
            bvalid_d = 1'b1;
        end

        if (rvalid_q && s_axil_rready) begin
            rvalid_d = 1'b0;
        end
        // rdata only moves on a new accept, so it stays put under rready backpressure.
        if (rd_en) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_acc_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            wr_acc_q  <= wr_acc_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_axil_awready = wr_acc_q;
    assign s_axil_wready  = wr_acc_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = AXI_RESP_OKAY;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = AXI_RESP_OKAY;

    assign kg_address       = reg_q[0];
    assign kg_address_valid = reg_q[1];
    assign kg_data          = reg_q[2];
    assign kg_data_valid    = reg_q[3];

    logic unused_ok;
    assign unused_ok = ^{s_axil_awprot, s_axil_arprot,
                         s_axil_awaddr[ADDR_WIDTH-1:5], s_axil_awaddr[1:0],
                         s_axil_araddr[ADDR_WIDTH-1:5], s_axil_araddr[1:0]};

endmodule

// File: tb/tb_axil_kg_reg_file.sv
// Scoreboard bench for axil_kg_reg_file: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_axil_kg_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [31:0] kg_address, kg_address_valid, kg_data, kg_data_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]  b_q[$];
    logic [31:0] r_q[$];

    always #5 clk = ~clk;

    axil_kg_reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .s_axil_awaddr    (awaddr),
        .s_axil_awprot    (3'b000),
        .s_axil_awvalid   (awvalid),
        .s_axil_awready   (awready),
        .s_axil_wdata     (wdata),
        .s_axil_wstrb     (wstrb),
        .s_axil_wvalid    (wvalid),
        .s_axil_wready    (wready),
        .s_axil_bresp     (bresp),
        .s_axil_bvalid    (bvalid),
        .s_axil_bready    (bready),
        .s_axil_araddr    (araddr),
        .s_axil_arprot    (3'b000),
        .s_axil_arvalid   (arvalid),
        .s_axil_arready   (arready),
        .s_axil_rdata     (rdata),
        .s_axil_rresp     (rresp),
        .s_axil_rvalid    (rvalid),
        .s_axil_rready    (rready),
        .kg_address       (kg_address),
        .kg_address_valid (kg_address_valid),
        .kg_data          (kg_data),
        .kg_data_valid    (kg_data_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: responses are consumed on the edge after this sample point.
    always @(negedge clk) begin
        if (rst === 1'b1 && bvalid && bready) begin
            if (b_q.size() == 0) check("b_unexpected", 32'(bvalid), 32'd0);
            else check("bresp", 32'(bresp), 32'(b_q.pop_front()));
        end
        if (rst === 1'b1 && rvalid && rready) begin
            check("rresp", 32'(rresp), 32'd0);
            if (r_q.size() == 0) check("r_unexpected", 32'(rvalid), 32'd0);
            else check("rdata", rdata, r_q.pop_front());
        end
    end

    task automatic wait_aw();
        int cnt = 0;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!awready && cnt < 20);
        check("aw_handshake", 32'(awready), 32'd1);
        check("w_with_aw", 32'(wready), 32'd1);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int lead, input bit auto_b);
        awaddr  = addr;
        awvalid = 1'b1;
        for (int i = 0; i < lead; i++) begin
            @(posedge clk); #1;
            check("aw_alone_waits", 32'(awready), 32'd0);
        end
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
        wait_aw();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        b_q.push_back(2'b00);
        if (auto_b) begin
            bready = 1'b1;
            @(posedge clk); #1;
            bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input int hold);
        int cnt = 0;
        araddr  = addr;
        arvalid = 1'b1;
        do begin
            @(posedge clk); #1;
            cnt++;
        end while (!arready && cnt < 20);
        check("ar_handshake", 32'(arready), 32'd1);
        arvalid = 1'b0;
        r_q.push_back(exp);
        for (int i = 0; i < hold; i++) begin
            check("r_hold_valid", 32'(rvalid), 32'd1);
            check("r_hold_data", rdata, exp);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_kg_address", kg_address, 32'd0);
        check("rst_kg_address_valid", kg_address_valid, 32'd0);
        check("rst_kg_data", kg_data, 32'd0);
        check("rst_kg_data_valid", kg_data_valid, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        axi_read(32'h00, 32'h0, 0);
        axi_read(32'h04, 32'h0, 0);
        axi_read(32'h08, 32'h0, 0);
        axi_read(32'h0C, 32'h0, 0);
        axi_read(32'h10, 32'h4B47_0001, 0);

        // Full-word write; value is visible when the ready pulse is seen.
        axi_write(32'h08, 32'h0000_00AB, 4'hF, 0, 1);
        check("full_write_kg_data", kg_data, 32'h0000_00AB);
        axi_read(32'h08, 32'h0000_00AB, 0);

        axi_write(32'h00, 32'h1122_3344, 4'hF, 0, 1);
        axi_write(32'h00, 32'hFFFF_FFFF, 4'b0101, 0, 1);
        check("strobe_kg_address", kg_address, 32'h11FF_33FF);
        axi_read(32'h00, 32'h11FF_33FF, 0);

        axi_write(32'h0C, 32'h0000_0005, 4'hF, 3, 1);
        check("skew_kg_data_valid", kg_data_valid, 32'h0000_0005);

        // Write response held off: a second pending write must wait.
        axi_write(32'h0C, 32'h0000_000A, 4'hF, 0, 0);
        check("bp_first_write", kg_data_valid, 32'h0000_000A);
        awaddr = 32'h0C; wdata = 32'h7; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_bvalid_held", 32'(bvalid), 32'd1);
            check("bp_no_accept", 32'(awready), 32'd0);
            check("bp_reg_kept", kg_data_valid, 32'h0000_000A);
        end
        bready = 1'b1;
        wait_aw();
        awvalid = 1'b0; wvalid = 1'b0;
        b_q.push_back(2'b00);
        check("bp_second_write", kg_data_valid, 32'h0000_0007);
        @(posedge clk); #1;
        bready = 1'b0;

        axi_read(32'h00, 32'h11FF_33FF, 5);

        axi_write(32'h14, 32'hDEAD_BEEF, 4'hF, 0, 1);
        check("unmapped_kg_address", kg_address, 32'h11FF_33FF);
        check("unmapped_kg_address_valid", kg_address_valid, 32'h0);
        check("unmapped_kg_data", kg_data, 32'h0000_00AB);
        check("unmapped_kg_data_valid", kg_data_valid, 32'h0000_0007);
        axi_read(32'h14, 32'h0, 0);

        axi_write(32'h24, 32'h1, 4'hF, 0, 1);
        check("alias_kg_address_valid", kg_address_valid, 32'h1);
        axi_read(32'h30, 32'h4B47_0001, 0);

        // Reset between accept and bready: must clear without a clock edge.
        axi_write(32'h04, 32'h3, 4'hF, 0, 0);
        check("pre_abort_kg_address_valid", kg_address_valid, 32'h3);
        #2 rst = 1'b0;
        #1;
        check("abort_bvalid", 32'(bvalid), 32'd0);
        check("abort_awready", 32'(awready), 32'd0);
        check("abort_kg_address_valid", kg_address_valid, 32'd0);
        check("abort_kg_data", kg_data, 32'd0);
        b_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        axi_read(32'h08, 32'h0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("b_queue_drained", 32'(b_q.size()), 32'd0);
        check("r_queue_drained", 32'(r_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
